// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared pixel type, width constant and pooling FSM states
package cnn_pkg;

  localparam int PIXEL_WIDTH = 32;

  typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - window/output counters and flat pixel indices for maxpool2d
module pool_addr_gen #(
  parameter int pool_size   = 2,
  parameter int input_width = 4,
  parameter int cnt_w       = 3,
  parameter int in_idx_w    = 5,
  parameter int out_idx_w   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [in_idx_w-1:0]  in_idx,
  output logic [out_idx_w-1:0] out_idx,
  output logic                 window_first,
  output logic                 window_last,
  output logic                 image_last
);

  localparam int output_width = input_width / pool_size;

  logic [cnt_w-1:0] kx, ky, ox, oy;
  logic kx_last, ky_last, ox_last, oy_last;

  assign kx_last = (kx == cnt_w'(pool_size - 1));
  assign ky_last = (ky == cnt_w'(pool_size - 1));
  assign ox_last = (ox == cnt_w'(output_width - 1));
  assign oy_last = (oy == cnt_w'(output_width - 1));

  // Walk kx fastest, then ky, then ox, then oy; clear restarts a run from pixel 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clear) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (enable) begin
      if (kx_last) begin
        kx <= '0;
        if (ky_last) begin
          ky <= '0;
          if (ox_last) begin
            ox <= '0;
            oy <= oy_last ? '0 : oy + cnt_w'(1);
          end else begin
            ox <= ox + cnt_w'(1);
          end
        end else begin
          ky <= ky + cnt_w'(1);
        end
      end else begin
        kx <= kx + cnt_w'(1);
      end
    end
  end

  // Flat row-major indices of the current input pixel and its output slot
  always_comb begin
    in_idx  = in_idx_w'((32'(oy) * pool_size + 32'(ky)) * input_width
                        + 32'(ox) * pool_size + 32'(kx));
    out_idx = out_idx_w'(32'(oy) * output_width + 32'(ox));
  end

  assign window_first = (kx == '0) && (ky == '0);
  assign window_last  = kx_last && ky_last;
  assign image_last   = window_last && ox_last && oy_last;

endmodule

// File: rtl/maxpool2d.sv
// rtl/maxpool2d.sv - sequential 2D max pooling, one pixel per cycle; optional ReLU clamp via MAXPOOL_RELU_EN
module maxpool2d
  import cnn_pkg::*;
#(
  parameter int pool_size   = 2,
  parameter int input_width = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [input_width*input_width*PIXEL_WIDTH-1:0]   input_image,
  output logic [(input_width/pool_size)*(input_width/pool_size)*PIXEL_WIDTH-1:0] output_image,
  output logic                                             busy,
  output logic                                             done
);

  localparam int output_width = input_width / pool_size;
  localparam int n_in         = input_width * input_width;
  localparam int n_out        = output_width * output_width;
  localparam int cnt_w        = $clog2(input_width) + 1;
  localparam int in_idx_w     = $clog2(n_in) + 1;
  localparam int out_idx_w    = $clog2(n_out) + 1;

  if (pool_size < 1) begin : g_bad_pool
    $error("maxpool2d: pool_size must be at least 1");
  end else if (input_width % pool_size != 0) begin : g_bad_width
    $error("maxpool2d: input_width must be a multiple of pool_size");
  end

  pool_state_t state, state_next;

  logic [in_idx_w-1:0]  in_idx;
  logic [out_idx_w-1:0] out_idx;
  logic window_first, window_last, image_last;
  pixel_t pix, pix_cmp, run_max, cand;

  pool_addr_gen #(
    .pool_size   (pool_size),
    .input_width (input_width),
    .cnt_w       (cnt_w),
    .in_idx_w    (in_idx_w),
    .out_idx_w   (out_idx_w)
  ) u_addr (
    .clk          (clk),
    .reset        (reset),
    .clear        ((state == IDLE) && start),
    .enable       (state == SCAN),
    .in_idx       (in_idx),
    .out_idx      (out_idx),
    .window_first (window_first),
    .window_last  (window_last),
    .image_last   (image_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: start is ignored during SCAN, and DONE waits for start to drop
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (image_last) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  // Select the current pixel and form the new running max
  always_comb begin
    pix = '0;
    for (int i = 0; i < n_in; i++) begin
      if (in_idx == in_idx_w'(i)) pix = input_image[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
`ifdef MAXPOOL_RELU_EN
    pix_cmp = (pix < 0) ? '0 : pix;
`else
    pix_cmp = pix;
`endif
    if (window_first) cand = pix_cmp;
    else              cand = (pix_cmp > run_max) ? pix_cmp : run_max;
  end

  // Running max and output slots; a slot only changes when its window closes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max      <= '0;
      output_image <= '0;
    end else if (state == SCAN) begin
      run_max <= cand;
      for (int j = 0; j < n_out; j++) begin
        if (window_last && (out_idx == out_idx_w'(j)))
          output_image[j*PIXEL_WIDTH +: PIXEL_WIDTH] <= cand;
      end
    end
  end

endmodule
